// File: rtl/instr_sequencer_4bit.sv
// Instruction sequencer for the 4-bit execute unit: loadable 16-word program memory,
// program counter, return stack, and one-issue-per-three-cycles FETCH/ISSUE/WAIT loop.
module instr_sequencer_4bit #(
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [3:0]  HALT_OP     = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [3:0]  load_addr,
    input  logic [11:0] load_data,
    input  logic        run,
    input  logic        ZERO_FLAG,
    output logic [3:0]  instruction,
    output logic [3:0]  AX,
    output logic [3:0]  BX,
    output logic        SEQUENTIAL,
    output logic [3:0]  pc,
    output logic [2:0]  stack_pointer,
    output logic        halted,
    output logic        stack_error
);

    localparam logic [3:0] OP_JZ   = 4'b1011;
    localparam logic [3:0] OP_CALL = 4'b1110;
    localparam logic [3:0] OP_RET  = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] mem [16];
    logic [3:0]  stack [8];
    logic [3:0]  sp;
    logic [11:0] fetch_word;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_fault;
    logic [2:0]  pop_idx;
    logic [3:0]  pc_inc;

    assign fetch_word  = mem[pc];
    assign stack_full  = (sp == 4'(STACK_DEPTH));
    assign stack_empty = (sp == 4'd0);
    assign pop_idx     = sp[2:0] - 3'd1;
    assign pc_inc      = pc + 4'd1;
    assign stack_fault = ((instruction == OP_CALL) && stack_full) ||
                         ((instruction == OP_RET)  && stack_empty);

    assign SEQUENTIAL    = (state != S_ISSUE);
    assign halted        = (state == S_HALT);
    assign stack_pointer = sp[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALT: if (run && !load_en) state_nxt = S_FETCH;
            S_FETCH:        state_nxt = (fetch_word[11:8] == HALT_OP) ? S_HALT : S_ISSUE;
            S_ISSUE:        state_nxt = S_WAIT;
            S_WAIT:         state_nxt = stack_fault ? S_HALT : S_FETCH;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // The output registers double as the instruction register; a fetched HALT word
    // is never latched so the last issued instruction stays visible while halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= '0;
            sp          <= '0;
            instruction <= '0;
            AX          <= '0;
            BX          <= '0;
            stack_error <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) mem[i] <= {HALT_OP, 8'h00};
            for (int unsigned i = 0; i < 8; i++) stack[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_en) mem[load_addr] <= load_data;
                end
                S_HALT: begin
                    if (load_en) begin
                        mem[load_addr] <= load_data;
                    end else if (run) begin
                        pc          <= '0;
                        sp          <= '0;
                        stack_error <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (fetch_word[11:8] != HALT_OP) begin
                        instruction <= fetch_word[11:8];
                        AX          <= fetch_word[7:4];
                        BX          <= fetch_word[3:0];
                    end
                end
                S_WAIT: begin
                    case (instruction)
                        OP_JZ: pc <= ZERO_FLAG ? AX : pc_inc;
                        OP_CALL: begin
                            if (stack_full) begin
                                stack_error <= 1'b1;
                            end else begin
                                stack[sp[2:0]] <= pc_inc;
                                sp             <= sp + 4'd1;
                                pc             <= AX;
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                stack_error <= 1'b1;
                            end else begin
                                sp <= sp - 4'd1;
                                pc <= stack[pop_idx];
                            end
                        end
                        default: pc <= pc_inc;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer_4bit.sv
// Directed self-checking bench for instr_sequencer_4bit: straight-line program loads,
// run pulses and hand-computed expectations checked with immediate assertions.
module tb_instr_sequencer_4bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [11:0] load_data = '0;
    logic        run = 1'b0;
    logic        ZERO_FLAG = 1'b0;
    logic [3:0]  instruction;
    logic [3:0]  AX;
    logic [3:0]  BX;
    logic        SEQUENTIAL;
    logic [3:0]  pc;
    logic [2:0]  stack_pointer;
    logic        halted;
    logic        stack_error;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    instr_sequencer_4bit #(
        .STACK_DEPTH(4),
        .HALT_OP(4'b0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .run(run),
        .ZERO_FLAG(ZERO_FLAG),
        .instruction(instruction),
        .AX(AX),
        .BX(BX),
        .SEQUENTIAL(SEQUENTIAL),
        .pc(pc),
        .stack_pointer(stack_pointer),
        .halted(halted),
        .stack_error(stack_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [3:0] addr, input logic [11:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_issue(input string tag);
        logic got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!SEQUENTIAL) begin
                got = 1'b1;
                break;
            end
        end
        chk(tag, 16'(got), 16'd1);
    endtask

    task automatic wait_halt(input string tag);
        logic got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (halted) begin
                got = 1'b1;
                break;
            end
        end
        chk(tag, 16'(got), 16'd1);
    endtask

    initial begin
        logic [3:0] seq_hist;

        // Reset values
        #1;
        chk("rst_seq", 16'(SEQUENTIAL), 16'd1);
        chk("rst_pc", 16'(pc), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outs", {instruction, AX, BX, 4'h0}, 16'h0000);
        chk("rst_flags", {13'd0, stack_pointer == 3'd0, halted, stack_error}, 16'b100);

        // 1: two instructions then HALT
        load_word(4'd0, 12'h134);
        load_word(4'd1, 12'h251);
        pulse_run();                       // cycle 1: FETCH
        seq_hist[0] = SEQUENTIAL;
        @(negedge clk);                    // cycle 2: ISSUE
        seq_hist[1] = SEQUENTIAL;
        chk("t1_issue1", {instruction, AX, BX, 4'h0}, 16'h1340);
        @(negedge clk);                    // cycle 3: WAIT
        seq_hist[2] = SEQUENTIAL;
        @(negedge clk);                    // cycle 4: FETCH
        seq_hist[3] = SEQUENTIAL;
        chk("t1_seq_c1to4", 16'(seq_hist), 16'b1101);
        @(negedge clk);                    // cycle 5: ISSUE
        chk("t1_seq_c5", 16'(SEQUENTIAL), 16'd0);
        chk("t1_issue2", {instruction, AX, BX, 4'h0}, 16'h2510);
        wait_halt("t1_halt_timeout");
        chk("t1_halt_pc", 16'(pc), 16'd2);
        chk("t1_hold", {instruction, AX, BX, 4'h0}, 16'h2510);

        // 2: JZ taken / not taken
        load_word(4'd0, 12'hB50);
        load_word(4'd1, 12'h000);
        ZERO_FLAG = 1'b1;
        pulse_run();
        chk("t2_run_clears_halt", 16'(halted), 16'd0);
        wait_halt("t2a_halt_timeout");
        chk("t2a_pc", 16'(pc), 16'd5);
        ZERO_FLAG = 1'b0;
        pulse_run();
        wait_halt("t2b_halt_timeout");
        chk("t2b_pc", 16'(pc), 16'd1);

        // 3: CALL / RET
        load_word(4'd0, 12'hE40);
        load_word(4'd4, 12'hF00);
        pulse_run();
        wait_issue("t3_issue1_timeout");
        chk("t3_op1", 16'(instruction), 16'hE);
        chk("t3_sp0", 16'(stack_pointer), 16'd0);
        wait_issue("t3_issue2_timeout");
        chk("t3_op2", 16'(instruction), 16'hF);
        chk("t3_sp1", 16'(stack_pointer), 16'd1);
        wait_halt("t3_halt_timeout");
        chk("t3_end", {8'd0, pc, 1'b0, stack_pointer}, 16'h0010);
        chk("t3_err", 16'(stack_error), 16'd0);

        // 4: self-CALL overflow
        load_word(4'd0, 12'hE00);
        pulse_run();
        for (int i = 0; i < 5; i++) wait_issue("t4_issue_timeout");
        chk("t4_sp_full", 16'(stack_pointer), 16'd4);
        wait_halt("t4_halt_timeout");
        chk("t4_err", {14'd0, stack_error, halted}, 16'b11);
        chk("t4_pc", 16'(pc), 16'd0);
        pulse_run();
        chk("t4_restart", {8'd0, pc, 1'b0, stack_pointer}, 16'h0000);
        chk("t4_restart_flags", {14'd0, stack_error, halted}, 16'b00);
        wait_halt("t4_halt2_timeout");
        chk("t4_err2", 16'(stack_error), 16'd1);

        // 5: pc wrap 15 -> 0, JZ at 0 jumps to 1 on the first pass
        load_word(4'd0, 12'hB10);
        for (int a = 1; a < 16; a++) load_word(4'(a), 12'h111);
        ZERO_FLAG = 1'b1;
        pulse_run();
        wait_issue("t5_first_timeout");
        chk("t5_first", {instruction, pc, 8'h00}, 16'hB000);
        for (int i = 0; i < 15; i++) wait_issue("t5_body_timeout");
        chk("t5_last", {instruction, pc, 8'h00}, 16'h1F00);
        wait_issue("t5_wrap_timeout");
        chk("t5_wrap", {instruction, pc, 8'h00}, 16'hB000);

        // 6: async reset in ISSUE (SEQUENTIAL is low here)
        #2 rst = 1'b1;
        #1;
        chk("t6_seq_async", 16'(SEQUENTIAL), 16'd1);
        chk("t6_outs", {instruction, AX, BX, pc}, 16'h0000);
        chk("t6_flags", {13'd0, stack_pointer == 3'd0, halted, stack_error}, 16'b100);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_seq_after", 16'(SEQUENTIAL), 16'd1);
        pulse_run();
        wait_halt("t6_halt_timeout");
        chk("t6_mem_cleared", {instruction, pc, 8'h00}, 16'h0000);
        for (int a = 1; a < 16; a += 7) begin
            load_word(4'd0, 12'hB00 | 12'(a << 4));
            pulse_run();
            wait_halt("t6_probe_timeout");
            chk("t6_probe_halt_op", 16'(pc), 16'(a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
